sat_engine_ctrl: RTL

Main sequencer for one Sat Engine variable-state bank, such as a tree of `var_state4` / `var_state2` instances. It loads the bank, then drives the decide → imply → analyze → backtrack loop through one-cycle command pulses. It owns the current decision level, computes the backtrack level from the bank's `max_level` report, and signals SAT, UNSAT or level overflow to the top-level scheduler.

---
 rtl/sat_engine_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sat_engine_ctrl.sv
// Main sequencer for one Sat Engine variable-state bank: load, then the
// decide -> imply -> analyze -> backtrack loop, driven by one-cycle command pulses.
module sat_engine_ctrl #(
  parameter int WIDTH_LVL = 10,
  parameter int WIDTH_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 wr_states_o,
  output logic                 dec_req_o,
  input  logic                 dec_ack_i,
  input  logic                 dec_none_i,
  output logic                 valid_from_decision_o,
  output logic [WIDTH_LVL-1:0] cur_level_o,
  output logic                 apply_imply_o,
  input  logic                 find_imply_i,
  input  logic                 find_conflict_i,
  output logic                 apply_analyze_o,
  input  logic [WIDTH_LVL-1:0] max_level_i,
  output logic                 apply_bkt_o,
  output logic [WIDTH_LVL-1:0] bkt_lvl_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sat_o,
  output logic                 unsat_o,
  output logic                 ovf_o,
  output logic [WIDTH_CNT-1:0] conflicts_o
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD      = 4'd1;
  localparam logic [3:0] S_IMPLY     = 4'd2;
  localparam logic [3:0] S_IMP_WAIT  = 4'd3;
  localparam logic [3:0] S_DECIDE    = 4'd4;
  localparam logic [3:0] S_DEC_VALID = 4'd5;
  localparam logic [3:0] S_ANALYZE   = 4'd6;
  localparam logic [3:0] S_ANL_WAIT  = 4'd7;
  localparam logic [3:0] S_BKT       = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

  localparam logic [WIDTH_LVL-1:0] LVL_ONE = {{(WIDTH_LVL-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_CNT-1:0] CNT_ONE = {{(WIDTH_CNT-1){1'b0}}, 1'b1};

  logic [3:0]           state;
  logic [3:0]           state_nx;
  logic [WIDTH_LVL-1:0] lvl_below;
  logic [WIDTH_LVL-1:0] bkt_next;

  // Clamping to level-1 guarantees every backtrack strictly lowers the level.
  assign lvl_below = cur_level_o - LVL_ONE;
  assign bkt_next  = (max_level_i < lvl_below) ? max_level_i : lvl_below;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start_i) state_nx = S_LOAD;
      S_LOAD:         state_nx = S_IMPLY;
      S_IMPLY:        state_nx = S_IMP_WAIT;
      S_IMP_WAIT: begin
        if (find_conflict_i)   state_nx = (cur_level_o == '0) ? S_DONE : S_ANALYZE;
        else if (find_imply_i) state_nx = S_IMPLY;
        else                   state_nx = S_DECIDE;
      end
      S_DECIDE: begin
        if (dec_none_i)     state_nx = S_DONE;
        else if (dec_ack_i) state_nx = (&cur_level_o) ? S_DONE : S_DEC_VALID;
      end
      S_DEC_VALID:    state_nx = S_IMPLY;
      S_ANALYZE:      state_nx = S_ANL_WAIT;
      S_ANL_WAIT:     state_nx = S_BKT;
      S_BKT:          state_nx = S_IMPLY;
      default:        state_nx = S_IDLE;
    endcase
    if (abort_i) state_nx = S_IDLE;
  end

  // Every output is a flop; pulses are decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= S_IDLE;
      wr_states_o           <= 1'b0;
      dec_req_o             <= 1'b0;
      valid_from_decision_o <= 1'b0;
      apply_imply_o         <= 1'b0;
      apply_analyze_o       <= 1'b0;
      apply_bkt_o           <= 1'b0;
      busy_o                <= 1'b0;
      done_o                <= 1'b0;
      sat_o                 <= 1'b0;
      unsat_o               <= 1'b0;
      ovf_o                 <= 1'b0;
      cur_level_o           <= '0;
      bkt_lvl_o             <= '0;
      conflicts_o           <= '0;
    end else begin
      state                 <= state_nx;
      wr_states_o           <= (state_nx == S_LOAD);
      dec_req_o             <= (state_nx == S_DECIDE);
      valid_from_decision_o <= (state_nx == S_DEC_VALID);
      apply_imply_o         <= (state_nx == S_IMPLY);
      apply_analyze_o       <= (state_nx == S_ANALYZE);
      apply_bkt_o           <= (state_nx == S_BKT);
      busy_o                <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      done_o                <= (state_nx == S_DONE);

      if (abort_i) begin
        sat_o   <= 1'b0;
        unsat_o <= 1'b0;
        ovf_o   <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start_i) begin
              cur_level_o <= '0;
              conflicts_o <= '0;
              sat_o       <= 1'b0;
              unsat_o     <= 1'b0;
              ovf_o       <= 1'b0;
            end
          end
          S_IMP_WAIT: begin
            if (find_conflict_i) begin
              if (cur_level_o == '0)  unsat_o     <= 1'b1;
              else if (!(&conflicts_o)) conflicts_o <= conflicts_o + CNT_ONE;
            end
          end
          S_DECIDE: begin
            if (dec_none_i)          sat_o       <= 1'b1;
            else if (dec_ack_i) begin
              if (&cur_level_o)      ovf_o       <= 1'b1;
              else                   cur_level_o <= cur_level_o + LVL_ONE;
            end
          end
          S_ANL_WAIT: bkt_lvl_o   <= bkt_next;
          S_BKT:      cur_level_o <= bkt_lvl_o;
          default: ;
        endcase
      end
    end
  end

endmodule
